// File: rtl/dataclk_reprog_ctrl_pkg.sv
// Shared types and constants for the data-clock reprogramming sequencer.
// Holds the FSM state enum, the PLL field widths, the reset defaults and
// the request validity check.
package dataclk_pkg;
  localparam int O_W     = 8;
  localparam int D_W     = 4;
  localparam int M_W     = 7;
  localparam int TIMER_W = 21;

  localparam logic [O_W-1:0] DEF_O = 8'd10;
  localparam logic [D_W-1:0] DEF_D = 4'd1;
  localparam logic [M_W-1:0] DEF_M = 7'd42;
  localparam logic [M_W-1:0] MIN_M = 7'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_TRIG,
    S_WAIT_LOCK,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [O_W-1:0] o;
    logic [D_W-1:0] d;
    logic [M_W-1:0] m;
  } pll_cfg_t;

  // A divider of zero or a multiplier below MIN_M would put the PLL out of range.
  function automatic logic cfg_valid(pll_cfg_t c);
    return (c.o != '0) && (c.d != '0) && (c.m >= MIN_M);
  endfunction
endpackage

// File: rtl/dataclk_reprog_ctrl_if.sv
// Control-register request bus plus clock_generator program/ready/locked
// handshake, bundled as one interface.
//   master : the sequencer (receives cfg_* and PLL status, drives dataclk_* and trigger)
//   slave  : register decode + clock_generator side
interface dataclk_reprog_ctrl_if;
  import dataclk_pkg::*;
  logic           cfg_wr;
  logic [O_W-1:0] cfg_O;
  logic [D_W-1:0] cfg_D;
  logic [M_W-1:0] cfg_M;
  logic           PLL_prog_done;
  logic           dataclk_locked;
  logic [O_W-1:0] dataclk_O;
  logic [D_W-1:0] dataclk_D;
  logic [M_W-1:0] dataclk_M;
  logic           PLL_prog_trigger;

  modport master (
    input  cfg_wr, cfg_O, cfg_D, cfg_M, PLL_prog_done, dataclk_locked,
    output dataclk_O, dataclk_D, dataclk_M, PLL_prog_trigger
  );
  modport slave (
    output cfg_wr, cfg_O, cfg_D, cfg_M, PLL_prog_done, dataclk_locked,
    input  dataclk_O, dataclk_D, dataclk_M, PLL_prog_trigger
  );
endinterface

// File: rtl/dataclk_reprog_ctrl_sync.sv
// Multi-flop single-bit synchroniser with async active-low reset (clears to 0).
//   clk, rst_n : destination clock / reset
//   d          : asynchronous input
//   q          : synchronised output, STAGES cycles later
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/dataclk_reprog_ctrl.sv
// Run-time SPI data-clock reprogramming sequencer (bus_clk domain).
// Captures a new O/D/M request, drains SPI acquisition, loads the new
// settings, pulses the clock_generator program trigger, waits for
// ready & locked under a timeout, then re-enables acquisition.
//   bus_clk, reset_n : clock, async active-low reset
//   pll              : request bus + clock_generator handshake (master side)
//   spi_run_req      : host run bit
//   spi_running      : SPI_4x busy flag (async, synchronised here)
//   spi_enable       : registered SPI start gate
//   busy             : sequence in progress (not IDLE / ERROR)
//   cfg_err, lock_err, lock_lost : sticky status, cleared only by reset
//   reprog_count     : completed reprograms, wrapping
module dataclk_reprog_ctrl
  import dataclk_pkg::*;
#(
  parameter logic [O_W-1:0] DEF_O       = dataclk_pkg::DEF_O,
  parameter logic [D_W-1:0] DEF_D       = dataclk_pkg::DEF_D,
  parameter logic [M_W-1:0] DEF_M       = dataclk_pkg::DEF_M,
  parameter int             MIN_WAIT    = 16,
  parameter int             TIMEOUT     = 1048576,
  parameter int             SYNC_STAGES = 2
) (
  input  logic                  bus_clk,
  input  logic                  reset_n,
  dataclk_reprog_ctrl_if.master pll,
  input  logic                  spi_run_req,
  input  logic                  spi_running,
  output logic                  spi_enable,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  lock_err,
  output logic                  lock_lost,
  output logic [7:0]            reprog_count
);
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] MW      = TIMER_W'(MIN_WAIT);
  localparam pll_cfg_t           DEF_CFG = '{o: DEF_O, d: DEF_D, m: DEF_M};

  state_t             state;
  pll_cfg_t           req, shadow, cur;
  logic               pending, trig, locked_q;
  logic               running_s, done_s, locked_s;
  logic [TIMER_W-1:0] timer;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_run  (.clk(bus_clk), .rst_n(reset_n), .d(spi_running),        .q(running_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (.clk(bus_clk), .rst_n(reset_n), .d(pll.PLL_prog_done),  .q(done_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (.clk(bus_clk), .rst_n(reset_n), .d(pll.dataclk_locked), .q(locked_s));

  assign req = '{o: pll.cfg_O, d: pll.cfg_D, m: pll.cfg_M};

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      shadow       <= DEF_CFG;
      cur          <= DEF_CFG;
      timer        <= '0;
      trig         <= 1'b0;
      locked_q     <= 1'b0;
      spi_enable   <= 1'b0;
      cfg_err      <= 1'b0;
      lock_err     <= 1'b0;
      lock_lost    <= 1'b0;
      reprog_count <= '0;
    end else begin
      trig       <= 1'b0;
      locked_q   <= locked_s;
      spi_enable <= spi_run_req & (state == S_IDLE) & locked_s;
      if (timer != '1) timer <= timer + 1'b1;
      if (pll.cfg_wr && !cfg_valid(req)) cfg_err <= 1'b1;
      if (state == S_IDLE && locked_q && !locked_s) lock_lost <= 1'b1;

      case (state)
        // ERROR leaves only through a fresh valid request, same as IDLE.
        S_IDLE, S_ERROR: if (pending) begin
          state   <= S_DRAIN;
          pending <= 1'b0;
          timer   <= '0;
        end
        S_DRAIN: begin
          if (!running_s) state <= S_LOAD;
          else if (timer == TO_LAST) begin
            state    <= S_ERROR;
            lock_err <= 1'b1;
          end
        end
        S_LOAD: begin
          cur   <= shadow;
          trig  <= 1'b1;
          state <= S_TRIG;
        end
        S_TRIG: begin
          timer <= '0;
          state <= S_WAIT_LOCK;
        end
        // Ready/locked are stale for the first MIN_WAIT cycles after the trigger.
        S_WAIT_LOCK: begin
          if (timer >= MW && done_s && locked_s) begin
            reprog_count <= reprog_count + 1'b1;
            state        <= S_IDLE;
          end else if (timer == TO_LAST) begin
            state    <= S_ERROR;
            lock_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so a write in the consume cycle keeps pending set.
      if (pll.cfg_wr && cfg_valid(req)) begin
        shadow  <= req;
        pending <= 1'b1;
      end
    end
  end

  assign busy                 = (state != S_IDLE) && (state != S_ERROR);
  assign pll.dataclk_O        = cur.o;
  assign pll.dataclk_D        = cur.d;
  assign pll.dataclk_M        = cur.m;
  assign pll.PLL_prog_trigger = trig;
endmodule

// File: doc/dataclk_reprog_ctrl.md
Name: dataclk_reprog_ctrl

Overview:
Sequencer that safely changes the SPI data-clock frequency at run time. It accepts new PLL settings (O/D/M) from the control-register path and gates SPI acquisition off until the serial link is idle. It then drives the clock generator's program/ready/locked handshake under a timeout and restores acquisition once the clock is stable. It sits between the control-register decode, clock_generator and SPI_4x, all in the bus_clk domain.

Parameters:
DEF_O, 8'd10, O value loaded at reset.
DEF_D, 4'd1, D value loaded at reset.
DEF_M, 7'd42, M value loaded at reset.
MIN_WAIT, 16, bus_clk cycles after trigger before ready/locked are sampled.
TIMEOUT, 1048576, max cycles in DRAIN or WAIT_LOCK (about 4.2 ms at 250 MHz).
SYNC_STAGES, 2, flip-flop depth of the input synchronisers.

Ports:
bus_clk  in  1  250 MHz PCIe clock, sole clock.
reset_n  in  1  asynchronous, active-low reset.
cfg_wr  in  1  one-cycle pulse: new cfg_O/D/M are valid.
cfg_O  in  8  requested output divider.
cfg_D  in  4  requested input divider.
cfg_M  in  7  requested multiplier.
spi_run_req  in  1  host run bit, level.
spi_running  in  1  SPI_4x busy flag; asynchronous to bus_clk, synchronised internally.
PLL_prog_done  in  1  clock_generator ready, level; synchronised internally.
dataclk_locked  in  1  clock_generator lock, level; synchronised internally.
dataclk_O  out  8  held O to clock_generator and SPI_4x.
dataclk_D  out  4  held D.
dataclk_M  out  7  held M.
PLL_prog_trigger  out  1  one-cycle program start pulse.
spi_enable  out  1  gates SPI start; registered.
busy  out  1  high in any state other than IDLE or ERROR.
cfg_err  out  1  sticky; set when a request has an invalid setting.
lock_err  out  1  sticky; set on a timeout.
lock_lost  out  1  sticky; set when lock falls while in IDLE.
reprog_count  out  8  completed reprograms; wraps at 255.

Behaviour:
- Reset values (async, reset_n=0): dataclk_O/D/M = DEF_O/DEF_D/DEF_M; all other outputs 0; state IDLE; pending request cleared.
- Synchronisers: spi_running, PLL_prog_done and dataclk_locked each pass through SYNC_STAGES flops. The rest of this section uses the synchronised versions (suffix _s).
- spi_enable is registered: next value = spi_run_req & (state==IDLE) & locked_s.
- Validity check: a request is invalid if O==0, D==0 or M<2. An invalid cfg_wr sets cfg_err, is dropped, and leaves state and outputs unchanged.
- Request capture: a valid cfg_wr loads a shadow O/D/M and sets the pending flag.
  - A later cfg_wr overwrites the shadow (last write wins).
  - A cfg_wr arriving in the same cycle the shadow is consumed takes priority: pending stays set.
- States:
  - IDLE: if pending, go to DRAIN, clear pending, zero the timer.
  - DRAIN: spi_enable=0. When spi_running_s==0, go to LOAD. On timer==TIMEOUT-1, go to ERROR.
  - LOAD: copy shadow to dataclk_O/D/M; go to TRIG. Outputs change only in this state.
  - TRIG: assert PLL_prog_trigger for exactly 1 cycle; zero the timer; go to WAIT_LOCK.
  - WAIT_LOCK: for timer<MIN_WAIT, ignore inputs. Afterwards, when PLL_prog_done_s & locked_s, increment reprog_count and go to IDLE. On timer==TIMEOUT-1, go to ERROR.
  - ERROR: spi_enable=0 and lock_err=1. A valid cfg_wr re-arms pending; the next cycle goes to DRAIN. There is no other exit.
- busy = (state not IDLE and not ERROR).
- lock_lost: set when locked_s falls while in IDLE. spi_enable deasserts through the locked_s term and reasserts automatically on relock.
- Sticky flags (cfg_err, lock_err, lock_lost) clear only on reset_n.
- Timer: a 21-bit counter that saturates. It is only meaningful in DRAIN and WAIT_LOCK.
- Latency: cfg_wr to PLL_prog_trigger is 4 cycles when spi_running_s is already 0 (capture, IDLE, DRAIN, LOAD; trigger asserted in the TRIG cycle).

Decomposition:
- Shared package dataclk_pkg: state enum; O/D/M widths (8/4/7); DEF_O/D/M constants; MIN_M=2; validity function.
- Sub-module sync_bit: parameterised SYNC_STAGES synchroniser with async active-low reset; instantiated three times.

Test Plan:
- Reset: hold reset_n=0, then release. Outputs O=10, D=1, M=42; all flags 0. With spi_run_req=1 and locked=1, spi_enable=1 after 3 cycles.
- Normal reprogram: cfg_wr with O=20, D=1, M=40; spi_running=0; model asserts ready and locked 30 cycles after trigger.
  - Trigger is a single pulse 4 cycles after cfg_wr.
  - dataclk_O=20 from LOAD onward.
  - spi_enable stays 0 until lock; reprog_count=1.
- Drain wait: spi_running held at 1 for 500 cycles. No trigger fires until 2 cycles after spi_running falls. lock_err stays 0.
- Lock timeout: ready never asserts. After TIMEOUT cycles: lock_err=1, state ERROR, spi_enable=0. A new valid cfg_wr leads to successful recovery and reprog_count increments.
- Invalid and back-to-back requests:
  - cfg_wr with M=1 sets cfg_err with no trigger.
  - Two valid cfg_wr during WAIT_LOCK (M=30, then M=50) produce exactly one extra reprogram, ending at M=50.
- Lock loss in IDLE: drop dataclk_locked for 100 cycles. lock_lost=1; spi_enable falls and returns about 3 cycles after relock.
